// File: rtl/pkt_sched_pkg.sv
// Shared types for the packet job scheduler:
// job, parse-request and completion records plus FSM states.
package pkt_sched_pkg;

  localparam int PQ_DEPTH = 2;

  typedef struct packed {
    logic [31:0] addr_in;
    logic [31:0] addr_out;
    logic [3:0]  byte_cnt;
    logic [3:0]  pkt_type;
    logic        parse;
  } job_t;

  typedef struct packed {
    logic        src;
    logic [31:0] addr;
  } preq_t;

  typedef struct packed {
    logic        src;
    logic        parsed;
    logic        timeout;
    logic [31:0] addr;
  } cmpl_t;

  typedef enum logic [1:0] {
    B_IDLE, B_START, B_WAIT, B_POST
  } bstate_t;

  typedef enum logic [1:0] {
    P_IDLE, P_START, P_WAIT, P_POST
  } pstate_t;

endpackage

// File: rtl/sched_fifo.sv
// Small synchronous first-word-fall-through FIFO.
// Ports: push/wdata in, pop in, rdata = head, empty/full flags.
module sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] P1 = AW'(1);
  localparam logic [AW:0]   C1 = (AW+1)'(1);
  localparam logic [AW:0]   CF = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          wr;
  logic          rd;

  assign empty = (cnt == '0);
  assign full  = (cnt == CF);
  // a pop frees the slot the push fills
  assign wr    = push & (~full | pop);
  assign rd    = pop & ~empty;
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + P1;
      if (rd) rptr <= rptr + P1;
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + C1;
        2'b01:   cnt <= cnt - C1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pkt_job_sched.sv
// Dispatches jobs to two packet builders, optionally chains a parse,
// and reports completions through a FWFT queue (done_* handshake).
module pkt_job_sched
  import pkt_sched_pkg::*;
#(
  parameter int WDOG_CYCLES = 1024,
  parameter int CQ_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_addr_in,
  input  logic [31:0] job_addr_out,
  input  logic [3:0]  job_byte_cnt,
  input  logic [3:0]  job_pkt_type,
  input  logic        job_parse,
  output logic        pb0_start,
  input  logic        pb0_busy,
  input  logic        pb0_irq,
  output logic [31:0] pb0_addr_in,
  output logic [31:0] pb0_addr_out,
  output logic [3:0]  pb0_byte_cnt,
  output logic [3:0]  pb0_pkt_type,
  output logic        pb1_start,
  input  logic        pb1_busy,
  input  logic        pb1_irq,
  output logic [31:0] pb1_addr_in,
  output logic [31:0] pb1_addr_out,
  output logic [3:0]  pb1_byte_cnt,
  output logic [3:0]  pb1_pkt_type,
  output logic        pp_start,
  input  logic        pp_busy,
  input  logic        pp_irq,
  output logic [31:0] pp_addr_hdr,
  output logic        done_valid,
  input  logic        done_ready,
  output logic        done_src,
  output logic        done_parsed,
  output logic        done_timeout,
  output logic [31:0] done_addr
);

  localparam logic [15:0] WD = 16'(WDOG_CYCLES);

  bstate_t     bst    [2];
  bstate_t     bst_nx [2];
  job_t        bjob   [2];
  logic [15:0] bwd    [2];
  logic [15:0] bwd_inc[2];
  logic [1:0]  bto;
  logic [1:0]  bhit;
  logic [1:0]  bbusy;
  logic [1:0]  birq;
  logic [1:0]  elig;
  logic [1:0]  take;
  logic [1:0]  want_pq;
  logic [1:0]  want_cq;
  logic [1:0]  pq_gnt;
  logic [1:0]  cq_gnt;
  logic        ptr;
  logic        sel;
  logic        accept;
  job_t        job_in;

  pstate_t     pst;
  pstate_t     pst_nx;
  logic [15:0] pwd;
  logic [15:0] pwd_inc;
  logic        phit;
  logic        pto;
  logic        psrc;
  logic        p_gnt;

  preq_t       pq_wdata;
  preq_t       pq_head;
  logic        pq_push;
  logic        pq_pop;
  logic        pq_empty;
  logic        pq_full;

  cmpl_t       cq_wdata;
  cmpl_t       cq_head;
  logic        cq_push;
  logic        cq_pop;
  logic        cq_empty;
  logic        cq_full;
  logic        cq_room;

  assign bbusy = {pb1_busy, pb0_busy};
  assign birq  = {pb1_irq, pb0_irq};

  assign job_in = '{
    addr_in:  job_addr_in,
    addr_out: job_addr_out,
    byte_cnt: job_byte_cnt,
    pkt_type: job_pkt_type,
    parse:    job_parse
  };

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i]    = (bst[i] == B_IDLE) & ~bbusy[i];
      bwd_inc[i] = bwd[i] + 16'd1;
      bhit[i]    = (bwd_inc[i] == WD);
      // timed-out builds skip the parser
      want_pq[i] = (bst[i] == B_POST)
                 & bjob[i].parse & ~bto[i];
      want_cq[i] = (bst[i] == B_POST)
                 & ~(bjob[i].parse & ~bto[i]);
    end
  end

  // async reset forces job_ready low
  assign job_ready = reset & (|elig);
  assign accept    = job_valid & job_ready;

  always_comb begin
    sel  = 1'b0;
    take = '0;
    if (&elig) sel = ptr;
    else       sel = elig[1];
    if (accept) take[sel] = 1'b1;
  end

  assign cq_pop  = done_valid & done_ready;
  assign cq_room = ~cq_full | cq_pop;
  assign p_gnt   = (pst == P_POST) & cq_room;

  assign pq_gnt[0] = want_pq[0] & ~pq_full;
  assign pq_gnt[1] = want_pq[1] & ~want_pq[0]
                   & ~pq_full;
  assign cq_gnt[0] = want_cq[0] & cq_room
                   & ~(pst == P_POST);
  assign cq_gnt[1] = want_cq[1] & cq_room
                   & ~(pst == P_POST) & ~want_cq[0];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bst_nx[i] = bst[i];
      unique case (bst[i])
        B_IDLE:  if (take[i]) bst_nx[i] = B_START;
        B_START: bst_nx[i] = B_WAIT;
        B_WAIT:  if (birq[i] | bhit[i]) bst_nx[i] = B_POST;
        B_POST:  if (pq_gnt[i] | cq_gnt[i])
                   bst_nx[i] = B_IDLE;
        default: bst_nx[i] = B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
      bto <= '0;
      for (int i = 0; i < 2; i++) begin
        bst[i]  <= B_IDLE;
        bjob[i] <= '0;
        bwd[i]  <= '0;
      end
    end else begin
      if (accept & (&elig)) ptr <= ~ptr;
      for (int i = 0; i < 2; i++) begin
        bst[i] <= bst_nx[i];
        if (take[i]) begin
          bjob[i] <= job_in;
          bto[i]  <= 1'b0;
        end
        if (bst[i] == B_START)
          bwd[i] <= '0;
        else if (bst[i] == B_WAIT)
          bwd[i] <= bwd_inc[i];
        if (bst[i] == B_WAIT && !birq[i] && bhit[i])
          bto[i] <= 1'b1;
      end
    end
  end

  assign pb0_start    = (bst[0] == B_START);
  assign pb0_addr_in  = bjob[0].addr_in;
  assign pb0_addr_out = bjob[0].addr_out;
  assign pb0_byte_cnt = bjob[0].byte_cnt;
  assign pb0_pkt_type = bjob[0].pkt_type;
  assign pb1_start    = (bst[1] == B_START);
  assign pb1_addr_in  = bjob[1].addr_in;
  assign pb1_addr_out = bjob[1].addr_out;
  assign pb1_byte_cnt = bjob[1].byte_cnt;
  assign pb1_pkt_type = bjob[1].pkt_type;

  assign pq_push  = |pq_gnt;
  assign pq_wdata = pq_gnt[0]
    ? '{src: 1'b0, addr: bjob[0].addr_out}
    : '{src: 1'b1, addr: bjob[1].addr_out};

  sched_fifo #(
    .W     ($bits(preq_t)),
    .DEPTH (PQ_DEPTH)
  ) u_pq (
    .clk   (clk),
    .reset (reset),
    .push  (pq_push),
    .wdata (pq_wdata),
    .pop   (pq_pop),
    .rdata (pq_head),
    .empty (pq_empty),
    .full  (pq_full)
  );

  assign pwd_inc  = pwd + 16'd1;
  assign phit     = (pwd_inc == WD);
  assign pp_start = (pst == P_START);
  // head stays queued until its completion is recorded
  assign pq_pop   = p_gnt;

  always_comb begin
    pst_nx = pst;
    unique case (pst)
      P_IDLE:  if (!pq_empty && !pp_busy) pst_nx = P_START;
      P_START: pst_nx = P_WAIT;
      P_WAIT:  if (pp_irq | phit) pst_nx = P_POST;
      P_POST:  if (cq_room) pst_nx = P_IDLE;
      default: pst_nx = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pst         <= P_IDLE;
      pwd         <= '0;
      pto         <= 1'b0;
      psrc        <= 1'b0;
      pp_addr_hdr <= '0;
    end else begin
      pst <= pst_nx;
      if (pst == P_IDLE && pst_nx == P_START) begin
        psrc        <= pq_head.src;
        pp_addr_hdr <= pq_head.addr;
        pto         <= 1'b0;
      end
      if (pst == P_START)
        pwd <= '0;
      else if (pst == P_WAIT)
        pwd <= pwd_inc;
      if (pst == P_WAIT && !pp_irq && phit)
        pto <= 1'b1;
    end
  end

  assign cq_push = p_gnt | (|cq_gnt);

  always_comb begin
    cq_wdata = '0;
    unique case (1'b1)
      p_gnt: cq_wdata = '{
        src: psrc, parsed: 1'b1,
        timeout: pto, addr: pp_addr_hdr};
      cq_gnt[0]: cq_wdata = '{
        src: 1'b0, parsed: 1'b0,
        timeout: bto[0], addr: bjob[0].addr_out};
      cq_gnt[1]: cq_wdata = '{
        src: 1'b1, parsed: 1'b0,
        timeout: bto[1], addr: bjob[1].addr_out};
      default: ;
    endcase
  end

  sched_fifo #(
    .W     ($bits(cmpl_t)),
    .DEPTH (CQ_DEPTH)
  ) u_cq (
    .clk   (clk),
    .reset (reset),
    .push  (cq_push),
    .wdata (cq_wdata),
    .pop   (cq_pop),
    .rdata (cq_head),
    .empty (cq_empty),
    .full  (cq_full)
  );

  // record fields read as zero while the queue is empty
  assign done_valid   = ~cq_empty;
  assign done_src     = done_valid & cq_head.src;
  assign done_parsed  = done_valid & cq_head.parsed;
  assign done_timeout = done_valid & cq_head.timeout;
  assign done_addr    = done_valid ? cq_head.addr : '0;

endmodule

// File: doc/pkt_job_sched.md
PKT_JOB_SCHED -- requirements
Module: pkt_job_sched

Interface
REQ-001 Parameter WDOG_CYCLES, default 1024: per-operation watchdog limit in clk cycles.
REQ-002 Parameter CQ_DEPTH, default 4: completion queue depth (power of 2).
REQ-003 clk  in  1  single clock, all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 job_valid/job_ready  in/out  1/1  build-job handshake.
REQ-006 job_addr_in, job_addr_out  in  32 each  source and destination addresses.
REQ-007 job_byte_cnt, job_pkt_type  in  4 each  job parameters.
REQ-008 job_parse  in  1  parse the built packet after build.
REQ-009 pbN_start  out  1  start pulse to builder N (N=0,1).
REQ-010 pbN_busy, pbN_irq  in  1 each  builder N status and completion pulse.
REQ-011 pbN_addr_in, pbN_addr_out  out  32 each  builder N addresses.
REQ-012 pbN_byte_cnt, pbN_pkt_type  out  4 each  builder N parameters.
REQ-013 pp_start  out  1  start pulse to parser.
REQ-014 pp_busy, pp_irq  in  1 each  parser status and completion pulse.
REQ-015 pp_addr_hdr  out  32  parser header address (the job's addr_out).
REQ-016 done_valid/done_ready  out/in  1/1  completion handshake.
REQ-017 done_src, done_parsed, done_timeout  out  1 each  completion record: builder used, parse executed, watchdog fired.
REQ-018 done_addr  out  32  completion record: job addr_out.

Function
REQ-019 Per builder FSM states: B_IDLE, B_START, B_WAIT, B_POST.
REQ-020 job_ready SHALL be 1 iff a builder is in B_IDLE with pbN_busy=0; a job is accepted on job_valid & job_ready.
REQ-021 Builder selection: round-robin pointer; if both eligible, pick the pointer's builder, then toggle the pointer to the other; if one eligible, pick it.
REQ-022 On accept: latch job into builder N registers, go B_START; pbN_start=1 for exactly that one cycle; go B_WAIT.
REQ-023 pbN_addr_*, pbN_byte_cnt, pbN_pkt_type SHALL hold stable from B_START until return to B_IDLE.
REQ-024 B_WAIT: pbN_irq=1 -> B_POST; pbN_irq outside B_WAIT ignored.
REQ-025 B_POST, parse=0: push completion {N,0,0,addr_out}; parse=1: push parse request {N,addr_out} to a 2-entry parse queue; return B_IDLE on the push cycle, stay in B_POST while the target queue is full.
REQ-026 Parser FSM: P_IDLE, P_START, P_WAIT, P_POST; leaves P_IDLE when parse queue non-empty and pp_busy=0; pp_start one-cycle pulse in P_START.
REQ-027 P_WAIT: pp_irq -> P_POST; P_POST pushes completion {src,1,0,addr}, pops parse queue, returns P_IDLE; stalls while completion queue full.
REQ-028 Watchdog: 16-bit counter per builder and for the parser, cleared on entering *_WAIT and incremented each cycle in *_WAIT; reaching WDOG_CYCLES exits as on irq with done_timeout=1, and a timed-out build is not parsed.
REQ-029 Completion queue: CQ_DEPTH-entry FIFO, first-word-fall-through; done_valid = not empty; pop on done_valid & done_ready.
REQ-030 Simultaneous completion pushes: parser has priority, then pb0, then pb1; losers remain in *_POST.
REQ-031 Simultaneous push and pop on a full queue: permitted, occupancy unchanged.
REQ-032 Completion order within a source is preserved; no ordering guarantee across sources.

Reset
REQ-033 reset=0 asynchronously: all FSMs idle, queues empty, pointer=pb0, watchdogs 0, all outputs 0 (job_ready=0 while in reset).
REQ-034 Reset mid-operation discards in-flight jobs and queued completions without reporting them.

Structure
REQ-035 Package pkt_sched_pkg: job struct, parse-request struct, completion struct, FSM state enums, parse-queue depth constant.
REQ-036 One sub-module sched_fifo (parameterized width/depth sync FIFO), instantiated for the parse queue and the completion queue.

Verification
REQ-037 Single job addr_out=0x100, parse=0; pb0_irq after 5 cycles -> pb0_start one pulse, completion {0,0,0,0x100}.
REQ-038 Three back-to-back jobs, builders idle -> dispatched to pb0, pb1, then pb0 once it returns idle; job_ready=0 while both are busy.
REQ-039 Two parse=1 jobs, both irq same cycle -> parser runs pb0's job, then pb1's; two completions with done_parsed=1.
REQ-040 WDOG_CYCLES=8, pb1 never irqs -> completion {1,0,1,addr} 8 cycles after start, pp_start never pulses.
REQ-041 done_ready=0, five parse=0 jobs -> four completions queued, fifth builder held in B_POST; done_ready=1 drains all five in order per source.
REQ-042 reset=0 asserted in B_WAIT -> outputs 0 immediately, done_valid=0 after release.
